// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface alu_muldiv_if #(
    parameter int unsigned WORD_WIDTH = `WORD_WIDTH
) ();
    logic                  start;
    logic [2:0]            op;
    logic [WORD_WIDTH-1:0] inA;
    logic [WORD_WIDTH-1:0] inB;
    logic                  busy;
    logic                  done;
    logic                  div_by_zero;
    logic [WORD_WIDTH-1:0] hi;
    logic [WORD_WIDTH-1:0] lo;

    modport master (
        output start, op, inA, inB,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, inA, inB,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/alu_muldiv.sv
// Bit-serial MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Operates on magnitudes; signs are re-applied in the FINISH state.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module alu_muldiv #(
    parameter int unsigned WORD_WIDTH = `WORD_WIDTH,
    parameter int unsigned CNT_WIDTH  = $clog2(WORD_WIDTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    alu_muldiv_if.slave  bus
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [WORD_WIDTH-1:0] mag_a;
    logic [WORD_WIDTH-1:0] mag_b;
    logic [WORD_WIDTH-1:0] acc_hi;
    logic [WORD_WIDTH-1:0] acc_lo;
    logic [WORD_WIDTH-1:0] orig_a;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  is_div;
    logic                  neg_q;
    logic                  neg_r;
    logic                  dbz;

    // Request decode and operand conditioning
    logic                  idle_c;
    logic                  launch_c;
    logic                  op_div_c;
    logic                  op_signed_c;
    logic                  a_neg_c;
    logic                  b_neg_c;
    logic [WORD_WIDTH-1:0] abs_a_c;
    logic [WORD_WIDTH-1:0] abs_b_c;

    always_comb begin
        idle_c      = (state == S_IDLE);
        op_div_c    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        op_signed_c = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        launch_c    = idle_c && bus.start &&
                      ((bus.op == OP_MULT) || (bus.op == OP_MULTU) || op_div_c);
        a_neg_c     = op_signed_c && bus.inA[WORD_WIDTH-1];
        b_neg_c     = op_signed_c && bus.inB[WORD_WIDTH-1];
        abs_a_c     = a_neg_c ? (~bus.inA + WORD_WIDTH'(1)) : bus.inA;
        abs_b_c     = b_neg_c ? (~bus.inB + WORD_WIDTH'(1)) : bus.inB;
    end

    // One iteration step: shift-add for multiply, restoring shift-subtract for divide
    logic [WORD_WIDTH:0]   mul_sum_c;
    logic [WORD_WIDTH:0]   div_trial_c;
    logic [WORD_WIDTH-1:0] div_shift_c;

    always_comb begin
        mul_sum_c   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);
        div_trial_c = {acc_hi, acc_lo[WORD_WIDTH-1]} - {1'b0, mag_b};
        div_shift_c = {acc_hi[WORD_WIDTH-2:0], acc_lo[WORD_WIDTH-1]};
    end

    // Sign correction of the finished magnitudes
    logic [2*WORD_WIDTH-1:0] prod_c;
    logic [2*WORD_WIDTH-1:0] prod_fix_c;
    logic [WORD_WIDTH-1:0]   quo_fix_c;
    logic [WORD_WIDTH-1:0]   rem_fix_c;
    logic [WORD_WIDTH-1:0]   res_hi_c;
    logic [WORD_WIDTH-1:0]   res_lo_c;

    always_comb begin
        prod_c     = {acc_hi, acc_lo};
        prod_fix_c = neg_q ? (~prod_c + (2*WORD_WIDTH)'(1)) : prod_c;
        quo_fix_c  = neg_q ? (~acc_lo + WORD_WIDTH'(1)) : acc_lo;
        rem_fix_c  = neg_r ? (~acc_hi + WORD_WIDTH'(1)) : acc_hi;
        if (!is_div) begin
            res_hi_c = prod_fix_c[2*WORD_WIDTH-1:WORD_WIDTH];
            res_lo_c = prod_fix_c[WORD_WIDTH-1:0];
        end else if (dbz) begin
            res_hi_c = orig_a;
            res_lo_c = '1;
        end else begin
            res_hi_c = rem_fix_c;
            res_lo_c = quo_fix_c;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (launch_c) state_next = S_RUN;
            S_RUN:    if (cnt == LAST_ITER) state_next = S_FINISH;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Datapath, HI/LO and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_a           <= '0;
            mag_b           <= '0;
            acc_hi          <= '0;
            acc_lo          <= '0;
            orig_a          <= '0;
            cnt             <= '0;
            is_div          <= 1'b0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            dbz             <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.hi          <= '0;
            bus.lo          <= '0;
        end else begin
            bus.busy        <= (state_next != S_IDLE);
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (launch_c) begin
                        mag_a  <= abs_a_c;
                        mag_b  <= abs_b_c;
                        acc_hi <= '0;
                        acc_lo <= op_div_c ? abs_a_c : abs_b_c;
                        orig_a <= bus.inA;
                        cnt    <= '0;
                        is_div <= op_div_c;
                        neg_q  <= a_neg_c ^ b_neg_c;
                        neg_r  <= op_div_c && a_neg_c;
                        dbz    <= op_div_c && (bus.inB == '0);
                    end else if (bus.start && (bus.op == OP_MTHI)) begin
                        bus.hi <= bus.inA;
                    end else if (bus.start && (bus.op == OP_MTLO)) begin
                        bus.lo <= bus.inA;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CNT_WIDTH'(1);
                    if (is_div) begin
                        if (!div_trial_c[WORD_WIDTH]) begin
                            acc_hi <= div_trial_c[WORD_WIDTH-1:0];
                            acc_lo <= {acc_lo[WORD_WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift_c;
                            acc_lo <= {acc_lo[WORD_WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= mul_sum_c[WORD_WIDTH:1];
                        acc_lo <= {mul_sum_c[0], acc_lo[WORD_WIDTH-1:1]};
                    end
                end
                S_FINISH: begin
                    bus.hi          <= res_hi_c;
                    bus.lo          <= res_lo_c;
                    bus.done        <= 1'b1;
                    bus.div_by_zero <= is_div && dbz;
                end
                default: ;
            endcase
        end
    end

    // OP_NOP and the reserved encoding fall through every branch above
    logic unused_nop_c;
    assign unused_nop_c = (OP_NOP == 3'b000);

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: products, quotients, divide-by-zero, MTHI/MTLO and reset abort.
module tb_alu_muldiv;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   edges;
    int   busy_cycles;
    int   done_seen;

    alu_muldiv_if #(.WORD_WIDTH(32)) bus ();

    alu_muldiv #(.WORD_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the request is sampled at the next rising edge.
    task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.inA   = a;
        bus.inB   = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'b000;
    endtask

    task automatic wait_done(output int n_edges, output int n_busy);
        n_edges = 0;
        n_busy  = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.done !== 1'b1 && n_edges < 100) begin
            @(negedge clk);
            n_edges++;
            if (bus.busy === 1'b1) n_busy++;
        end
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.inA   = '0;
        bus.inB   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_dbz",  64'(bus.div_by_zero), 64'd0);
        check("reset_hi",   64'(bus.hi), 64'd0);
        check("reset_lo",   64'(bus.lo), 64'd0);

        // MULTU max x max, with latency and busy width
        start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_busy_rise", 64'(bus.busy), 64'd1);
        check("multu_hi_held",   64'(bus.hi), 64'd0);
        wait_done(edges, busy_cycles);
        check("multu_latency", 64'(edges), 64'd33);
        check("multu_busy_cycles", 64'(busy_cycles), 64'd33);
        check("multu_busy_in_done", 64'(bus.busy), 64'd0);
        check("multu_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        check("multu_lo", 64'(bus.lo), 64'h0000_0001);
        @(negedge clk);
        check("multu_done_pulse", 64'(bus.done), 64'd0);

        // MULT -3 x 7, then MULTU 2 x 3 issued in the done cycle
        start_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(edges, busy_cycles);
        check("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(bus.lo), 64'hFFFF_FFEB);
        start_op(OP_MULTU, 32'd2, 32'd3);
        check("b2b_busy", 64'(bus.busy), 64'd1);
        wait_done(edges, busy_cycles);
        check("b2b_latency", 64'(edges), 64'd33);
        check("b2b_hi", 64'(bus.hi), 64'd0);
        check("b2b_lo", 64'(bus.lo), 64'd6);

        // Signed and unsigned divide
        start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(edges, busy_cycles);
        check("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("div_dbz", 64'(bus.div_by_zero), 64'd0);
        start_op(OP_DIVU, 32'd7, 32'd2);
        wait_done(edges, busy_cycles);
        check("divu_lo", 64'(bus.lo), 64'd3);
        check("divu_hi", 64'(bus.hi), 64'd1);

        // Divide by zero, then signed overflow
        start_op(OP_DIV, 32'h1234_5678, 32'd0);
        wait_done(edges, busy_cycles);
        check("dbz_done", 64'(bus.done), 64'd1);
        check("dbz_flag", 64'(bus.div_by_zero), 64'd1);
        check("dbz_hi", 64'(bus.hi), 64'h1234_5678);
        check("dbz_lo", 64'(bus.lo), 64'hFFFF_FFFF);
        @(negedge clk);
        check("dbz_flag_pulse", 64'(bus.div_by_zero), 64'd0);
        start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(edges, busy_cycles);
        check("ovf_lo", 64'(bus.lo), 64'h8000_0000);
        check("ovf_hi", 64'(bus.hi), 64'd0);
        check("ovf_dbz", 64'(bus.div_by_zero), 64'd0);
        @(negedge clk);

        // MTHI in idle, then MTLO and another start while busy are ignored
        start_op(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        check("mthi_hi", 64'(bus.hi), 64'hDEAD_BEEF);
        check("mthi_busy", 64'(bus.busy), 64'd0);
        check("mthi_done", 64'(bus.done), 64'd0);
        start_op(OP_MULTU, 32'h10, 32'h20);
        check("run_hi_held", 64'(bus.hi), 64'hDEAD_BEEF);
        start_op(OP_MTLO, 32'h1, 32'd0);
        check("mtlo_ignored", 64'(bus.lo), 64'h8000_0000);
        start_op(OP_DIVU, 32'd100, 32'd0);
        wait_done(edges, busy_cycles);
        check("busy_start_latency", 64'(edges), 64'd31);
        check("busy_start_hi", 64'(bus.hi), 64'd0);
        check("busy_start_lo", 64'(bus.lo), 64'h200);
        check("busy_start_dbz", 64'(bus.div_by_zero), 64'd0);
        @(negedge clk);
        check("busy_start_no_run", 64'(bus.busy), 64'd0);

        // Reset in the middle of MULTU aborts it
        bus.inA = 32'h55;
        start_op(OP_MTLO, 32'h55, 32'd0);
        start_op(OP_MULTU, 32'd5, 32'd5);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
